// File: rtl/hash_axis_bridge.sv
// hash_axis_bridge: AXI-Stream front end for hash_table with holding stage, credit-controlled response FIFO, sequence tags and local rejection of op 11; optional HASH_AXIS_STATS_EN adds stat_req_count/stat_err_count/stat_stall_cycles outputs. Ports: clk, reset, s_axis_* request slave, m_axis_* response master (tuser = tag).
module hash_table #(
  parameter int KEY_WIDTH = 15,
  parameter int DATA_WIDTH = 15,
  parameter int NUMBER_OF_TABLES = 10,
  parameter int BUCKET_BITS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic valid_i,
  input  logic [1:0] op_i,
  input  logic [KEY_WIDTH-1:0] key_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic ready_o,
  input  logic ready_i,
  output logic valid_o,
  output logic [DATA_WIDTH-1:0] read_data_o,
  output logic key_already_present_o,
  output logic no_element_found_o,
  output logic no_write_space_o,
  output logic no_deletion_target_o
);
  localparam int NB = 1 << BUCKET_BITS;
  logic [NB-1:0] v_q [NUMBER_OF_TABLES];
  logic [KEY_WIDTH-1:0] k_q [NUMBER_OF_TABLES][NB];
  logic [DATA_WIDTH-1:0] d_q [NUMBER_OF_TABLES][NB];
  logic req_v_q, out_v_q;
  logic [1:0] req_op_q;
  logic [KEY_WIDTH-1:0] req_key_q;
  logic [DATA_WIDTH-1:0] req_data_q, out_data_q, rd;
  logic kap_q, nef_q, nws_q, ndt_q, hit, taken;
  logic [NUMBER_OF_TABLES-1:0] hit_vec, free_oh;
  logic [BUCKET_BITS-1:0] idx [NUMBER_OF_TABLES];
  function automatic logic [BUCKET_BITS-1:0] hidx(input logic [KEY_WIDTH-1:0] key, input int t);
    logic [KEY_WIDTH+7:0] p;
    p = (KEY_WIDTH+8)'(key) * (KEY_WIDTH+8)'(2*t+3);
    return p[BUCKET_BITS-1:0] ^ p[2*BUCKET_BITS-1:BUCKET_BITS] ^ BUCKET_BITS'(t);
  endfunction
  for (genvar g = 0; g < NUMBER_OF_TABLES; g++) begin : g_idx
    assign idx[g] = hidx(req_key_q, g);
  end
  assign ready_o = ready_i;
  assign valid_o = out_v_q;
  assign read_data_o = out_data_q;
  assign key_already_present_o = kap_q;
  assign no_element_found_o = nef_q;
  assign no_write_space_o = nws_q;
  assign no_deletion_target_o = ndt_q;
  // Keys are unique across tables, so OR-ing hit data yields the single match; inserts go to the first free way.
  always_comb begin
    hit_vec = '0;
    free_oh = '0;
    taken = 1'b0;
    rd = '0;
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      hit_vec[t] = v_q[t][idx[t]] && k_q[t][idx[t]] == req_key_q;
      free_oh[t] = !v_q[t][idx[t]] && !taken;
      taken = taken | !v_q[t][idx[t]];
      rd = rd | (hit_vec[t] ? d_q[t][idx[t]] : '0);
    end
    hit = |hit_vec;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      req_v_q <= 1'b0;
      out_v_q <= 1'b0;
      for (int t = 0; t < NUMBER_OF_TABLES; t++) v_q[t] <= '0;
    end else begin
      req_v_q <= valid_i && ready_o;
      out_v_q <= req_v_q;
      if (req_v_q)
        for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
          if (req_op_q == 2'd2 && hit_vec[t]) v_q[t][idx[t]] <= 1'b0;
          if (req_op_q == 2'd1 && !hit && free_oh[t]) begin
            v_q[t][idx[t]] <= 1'b1;
            k_q[t][idx[t]] <= req_key_q;
            d_q[t][idx[t]] <= req_data_q;
          end
        end
    end
    if (valid_i && ready_o) begin
      req_op_q <= op_i;
      req_key_q <= key_i;
      req_data_q <= data_i;
    end
    if (req_v_q) begin
      out_data_q <= (req_op_q == 2'd0 && hit) ? rd : '0;
      kap_q <= req_op_q == 2'd1 && hit;
      nef_q <= req_op_q == 2'd0 && !hit;
      nws_q <= req_op_q == 2'd1 && !hit && !taken;
      ndt_q <= req_op_q == 2'd2 && !hit;
    end
  end
endmodule

module hash_axis_bridge #(
  parameter int KEY_WIDTH = 15,
  parameter int DATA_WIDTH = 15,
  parameter int NUMBER_OF_TABLES = 10,
  parameter int AXIS_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int SEQ_WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
  input  logic s_axis_tvalid,
  output logic s_axis_tready,
  output logic [AXIS_WIDTH-1:0] m_axis_tdata,
  output logic [SEQ_WIDTH-1:0] m_axis_tuser,
  output logic m_axis_tvalid,
  input  logic m_axis_tready
`ifdef HASH_AXIS_STATS_EN
  ,
  output logic [31:0] stat_req_count,
  output logic [31:0] stat_err_count,
  output logic [31:0] stat_stall_cycles
`endif
);
  localparam int KD = KEY_WIDTH + DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  logic hold_valid_q;
  logic [1:0] hold_op_q;
  logic [KEY_WIDTH-1:0] hold_key_q;
  logic [DATA_WIDTH-1:0] hold_data_q;
  logic [SEQ_WIDTH-1:0] hold_tag_q, seq_q, push_tag;
  logic [CW-1:0] in_flight_q, in_flight_d, cnt_q, cnt_d;
  logic [CW:0] credits;
  logic [SEQ_WIDTH-1:0] tag_mem_q [FIFO_DEPTH];
  logic [PW-1:0] tag_wr_q, tag_rd_q, wr_q, rd_q;
  logic [AXIS_WIDTH-1:0] rsp_mem_q [FIFO_DEPTH];
  logic [SEQ_WIDTH-1:0] rsp_tag_q [FIFO_DEPTH];
  logic [AXIS_WIDTH-1:0] tbl_word, push_word;
  logic room, legal, issue_leg, issue_ill, issue, accept, push, pop, empty;
  logic ht_ready, ht_valid, kap, nef, nws, ndt;
  logic [DATA_WIDTH-1:0] ht_data;
  hash_table #(.KEY_WIDTH(KEY_WIDTH), .DATA_WIDTH(DATA_WIDTH), .NUMBER_OF_TABLES(NUMBER_OF_TABLES)) u_table (
    .clk(clk), .reset(reset), .valid_i(issue_leg), .op_i(hold_op_q), .key_i(hold_key_q), .data_i(hold_data_q),
    .ready_o(ht_ready), .ready_i(1'b1), .valid_o(ht_valid), .read_data_o(ht_data),
    .key_already_present_o(kap), .no_element_found_o(nef), .no_write_space_o(nws), .no_deletion_target_o(ndt)
  );
  // Credits cover both in-flight table requests and queued responses, so the FIFO can never overflow.
  assign credits = {1'b0, in_flight_q} + {1'b0, cnt_q};
  assign room = credits < (CW+1)'(FIFO_DEPTH);
  assign legal = hold_op_q != 2'b11;
  assign issue_leg = hold_valid_q && legal && room && ht_ready;
  // Illegal ops answer locally only once the table has drained, keeping responses in request order.
  assign issue_ill = hold_valid_q && !legal && in_flight_q == '0 && room;
  assign issue = issue_leg || issue_ill;
  assign s_axis_tready = !reset && (!hold_valid_q || issue);
  assign accept = s_axis_tvalid && s_axis_tready;
  assign push = ht_valid || issue_ill;
  assign empty = cnt_q == '0;
  assign pop = !empty && m_axis_tready;
  assign m_axis_tvalid = !empty;
  assign m_axis_tdata = empty ? '0 : rsp_mem_q[rd_q];
  assign m_axis_tuser = empty ? '0 : rsp_tag_q[rd_q];
  always_comb begin
    tbl_word = '0;
    tbl_word[DATA_WIDTH-1:0] = ht_data;
    tbl_word[AXIS_WIDTH-1] = kap;
    tbl_word[AXIS_WIDTH-2] = nef;
    tbl_word[AXIS_WIDTH-3] = nws;
    tbl_word[AXIS_WIDTH-4] = ndt;
    push_word = issue_ill ? AXIS_WIDTH'(1) << (AXIS_WIDTH-5) : tbl_word;
    push_tag = issue_ill ? hold_tag_q : tag_mem_q[tag_rd_q];
    in_flight_d = in_flight_q + CW'(issue_leg) - CW'(ht_valid);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      seq_q <= '0;
      in_flight_q <= '0;
      cnt_q <= '0;
      tag_wr_q <= '0;
      tag_rd_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (accept) begin
        hold_valid_q <= 1'b1;
        hold_op_q <= s_axis_tdata[KD+1:KD];
        hold_key_q <= s_axis_tdata[KD-1:DATA_WIDTH];
        hold_data_q <= s_axis_tdata[DATA_WIDTH-1:0];
        hold_tag_q <= seq_q;
        seq_q <= seq_q + 1'b1;
      end else if (issue) hold_valid_q <= 1'b0;
      if (issue_leg) begin
        tag_mem_q[tag_wr_q] <= hold_tag_q;
        tag_wr_q <= tag_wr_q + 1'b1;
      end
      if (ht_valid) tag_rd_q <= tag_rd_q + 1'b1;
      if (push) begin
        rsp_mem_q[wr_q] <= push_word;
        rsp_tag_q[wr_q] <= push_tag;
        wr_q <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      in_flight_q <= in_flight_d;
      cnt_q <= cnt_d;
    end
  end
`ifdef HASH_AXIS_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_req_count <= '0;
      stat_err_count <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (accept && stat_req_count != '1) stat_req_count <= stat_req_count + 1'b1;
      if (push && |push_word[AXIS_WIDTH-1:AXIS_WIDTH-5] && stat_err_count != '1) stat_err_count <= stat_err_count + 1'b1;
      if (hold_valid_q && !issue && stat_stall_cycles != '1) stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_hash_axis_bridge.sv
// tb_hash_axis_bridge: randomized self-checking bench for hash_axis_bridge against a key/value reference model
module tb_hash_axis_bridge;
  localparam int KW = 15, DW = 15, NT = 10, AW = 32, FD = 4, SW = 8;
  logic clk = 0, reset = 1;
  logic [AW-1:0] s_tdata = '0, m_tdata;
  logic s_tvalid = 0, s_tready, m_tvalid, m_tready = 0;
  logic [SW-1:0] m_tuser;
`ifdef HASH_AXIS_STATS_EN
  logic [31:0] st_req, st_err, st_stall;
`endif
  always #5 clk = ~clk;
  hash_axis_bridge #(.KEY_WIDTH(KW), .DATA_WIDTH(DW), .NUMBER_OF_TABLES(NT), .AXIS_WIDTH(AW), .FIFO_DEPTH(FD), .SEQ_WIDTH(SW)) dut (
    .clk(clk), .reset(reset), .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready)
`ifdef HASH_AXIS_STATS_EN
    , .stat_req_count(st_req), .stat_err_count(st_err), .stat_stall_cycles(st_stall)
`endif
  );
  int n_cmp = 0, n_fail = 0;
  logic [AW-1:0] pend_q[$];
  logic [AW+SW-1:0] exp_q[$], rx_q[$];
  logic [DW-1:0] mem[logic [KW-1:0]];
  logic [SW-1:0] seq;
  logic [KW-1:0] pool[8];
  function automatic logic [AW-1:0] mk(input logic [1:0] op, input logic [KW-1:0] k, input logic [DW-1:0] d);
    return {op, k, d};
  endfunction
  // Table semantics: write never overwrites an existing key; key pool stays below NT so no write runs out of space.
  function automatic logic [AW-1:0] model(input logic [AW-1:0] r);
    logic [1:0] op;
    logic [KW-1:0] k;
    logic [AW-1:0] o;
    op = r[AW-1:AW-2];
    k = r[KW+DW-1:DW];
    o = '0;
    if (op == 2'd0) begin
      if (mem.exists(k)) o[DW-1:0] = mem[k];
      else o[AW-2] = 1'b1;
    end else if (op == 2'd1) begin
      if (mem.exists(k)) o[AW-1] = 1'b1;
      else mem[k] = r[DW-1:0];
    end else if (op == 2'd2) begin
      if (mem.exists(k)) mem.delete(k);
      else o[AW-4] = 1'b1;
    end else o[AW-5] = 1'b1;
    return o;
  endfunction
  always @(negedge clk) if (!reset && m_tvalid && m_tready) rx_q.push_back({m_tuser, m_tdata});
  task automatic step();
    logic hs;
    @(negedge clk);
    hs = s_tvalid && s_tready;
    @(posedge clk);
    #1;
    if (hs) begin
      exp_q.push_back({seq, model(pend_q[0])});
      seq = seq + 1'b1;
      void'(pend_q.pop_front());
    end
    s_tvalid = pend_q.size() != 0;
    s_tdata = s_tvalid ? pend_q[0] : '0;
  endtask
  task automatic drain(input int budget);
    int c = 0;
    while ((pend_q.size() != 0 || rx_q.size() < exp_q.size()) && c < budget) begin
      step();
      c++;
    end
    if (c >= budget) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d responses, want %0d", rx_q.size(), exp_q.size());
    end
    repeat (3) step();
  endtask
  task automatic clear_model();
    pend_q.delete();
    exp_q.delete();
    rx_q.delete();
    mem.delete();
    seq = '0;
  endtask
  task automatic do_reset();
    reset = 1;
    s_tvalid = 0;
    s_tdata = '0;
    @(posedge clk);
    #1;
    reset = 0;
    clear_model();
  endtask
  task automatic test_reset();
    reset = 1;
    m_tready = 1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp += 4;
    if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready: got %b want 0", s_tready); end
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b want 0", m_tvalid); end
    if (m_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata: got %h want 0", m_tdata); end
    if (m_tuser !== '0) begin n_fail++; $display("FAIL reset_tuser: got %h want 0", m_tuser); end
    reset = 0;
    #1;
    n_cmp++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL post_reset_tready: got %b want 1", s_tready); end
    clear_model();
  endtask
  task automatic test_write_read();
    do_reset();
    m_tready = 1;
    pend_q.push_back(mk(2'd1, 15'h0012, 15'h0ABC));
    pend_q.push_back(mk(2'd0, 15'h0012, 15'h0000));
    drain(200);
    n_cmp++;
    if (rx_q.size() != 2) begin n_fail++; $display("FAIL wr_rd_count: got %0d want 2", rx_q.size()); end
    else begin
      n_cmp += 2;
      if (rx_q[0] !== {8'd0, 32'h0}) begin n_fail++; $display("FAIL wr_rsp: got %h want %h", rx_q[0], {8'd0, 32'h0}); end
      if (rx_q[1] !== {8'd1, 32'h0ABC}) begin n_fail++; $display("FAIL rd_rsp: got %h want %h", rx_q[1], {8'd1, 32'h0ABC}); end
    end
  endtask
  task automatic test_absent();
    do_reset();
    m_tready = 1;
    pend_q.push_back(mk(2'd0, 15'h0777, 15'h0));
    drain(200);
    n_cmp++;
    if (rx_q.size() != 1) begin n_fail++; $display("FAIL absent_count: got %0d want 1", rx_q.size()); end
    else begin
      n_cmp++;
      if (rx_q[0] !== {8'd0, 32'h4000_0000}) begin n_fail++; $display("FAIL absent_rsp: got %h want %h", rx_q[0], {8'd0, 32'h4000_0000}); end
    end
  endtask
  task automatic test_backpressure();
    logic [AW+SW-1:0] held;
    logic seen;
    do_reset();
    m_tready = 0;
    pend_q.push_back(mk(2'd1, pool[0], 15'h1234));
    for (int i = 0; i < 5; i++) pend_q.push_back(mk(2'd0, pool[i % 2], 15'h0));
    seen = 0;
    held = '0;
    for (int c = 0; c < 25; c++) begin
      step();
      if (seen) begin
        n_cmp++;
        if (!m_tvalid || {m_tuser, m_tdata} !== held) begin n_fail++; $display("FAIL stall_stable: got %b/%h want 1/%h", m_tvalid, {m_tuser, m_tdata}, held); end
      end else if (m_tvalid) begin
        seen = 1;
        held = {m_tuser, m_tdata};
      end
    end
    n_cmp += 3;
    if (exp_q.size() != FD + 1) begin n_fail++; $display("FAIL stall_accepted: got %0d want %0d", exp_q.size(), FD + 1); end
    if (s_tready !== 1'b0) begin n_fail++; $display("FAIL stall_tready: got %b want 0", s_tready); end
    if (rx_q.size() != 0) begin n_fail++; $display("FAIL stall_rx: got %0d want 0", rx_q.size()); end
    m_tready = 1;
    drain(200);
    n_cmp++;
    if (rx_q.size() != 6 || exp_q.size() != 6) begin n_fail++; $display("FAIL bp_count: got %0d want 6", rx_q.size()); end
    else for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_rsp%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
    end
  endtask
  task automatic test_illegal();
    do_reset();
    m_tready = 1;
    pend_q.push_back(mk(2'd0, pool[3], 15'h0));
    pend_q.push_back(mk(2'd3, pool[3], 15'h7FFF));
    pend_q.push_back(mk(2'd0, pool[4], 15'h0));
    drain(200);
    n_cmp++;
    if (rx_q.size() != 3) begin n_fail++; $display("FAIL illegal_count: got %0d want 3", rx_q.size()); end
    else begin
      n_cmp++;
      if (rx_q[1] !== {8'd1, 32'h0800_0000}) begin n_fail++; $display("FAIL illegal_rsp: got %h want %h", rx_q[1], {8'd1, 32'h0800_0000}); end
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL illegal_seq%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      end
    end
  endtask
  task automatic test_midreset();
    do_reset();
    m_tready = 1;
    for (int i = 0; i < 3; i++) pend_q.push_back(mk(2'd0, pool[i], 15'h0));
    repeat (4) step();
    reset = 1;
    s_tvalid = 0;
    @(posedge clk);
    #1;
    reset = 0;
    clear_model();
    #1;
    n_cmp += 2;
    if (m_tvalid !== 1'b0) begin n_fail++; $display("FAIL midreset_tvalid: got %b want 0", m_tvalid); end
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL midreset_tready: got %b want 1", s_tready); end
    pend_q.push_back(mk(2'd0, pool[5], 15'h0));
    drain(200);
    n_cmp++;
    if (rx_q.size() != 1) begin n_fail++; $display("FAIL midreset_count: got %0d want 1", rx_q.size()); end
    else begin
      n_cmp++;
      if (rx_q[0] !== {8'd0, 32'h4000_0000}) begin n_fail++; $display("FAIL midreset_rsp: got %h want %h", rx_q[0], {8'd0, 32'h4000_0000}); end
    end
  endtask
  task automatic test_random_wrap();
    int c = 0;
    int errs = 0;
    do_reset();
    for (int i = 0; i < 260; i++)
      pend_q.push_back(mk(2'($urandom_range(0, 3)), pool[$urandom_range(0, 7)], 15'($urandom)));
    while (pend_q.size() != 0 && c < 5000) begin
      m_tready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    m_tready = 1;
    drain(500);
    n_cmp++;
    if (rx_q.size() != 260 || exp_q.size() != 260) begin n_fail++; $display("FAIL rand_count: got %0d want 260", rx_q.size()); end
    else begin
      for (int i = 0; i < 260; i++) begin
        n_cmp++;
        if (rx_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_rsp%0d: got %h want %h", i, rx_q[i], exp_q[i]); end
        if (|exp_q[i][AW-1:AW-5]) errs++;
      end
      n_cmp += 2;
      if (rx_q[255][AW+SW-1:AW] !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", rx_q[255][AW+SW-1:AW]); end
      if (rx_q[256][AW+SW-1:AW] !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", rx_q[256][AW+SW-1:AW]); end
    end
`ifdef HASH_AXIS_STATS_EN
    n_cmp += 2;
    if (st_req !== 32'd260) begin n_fail++; $display("FAIL stat_req: got %0d want 260", st_req); end
    if (st_err !== 32'(errs)) begin n_fail++; $display("FAIL stat_err: got %0d want %0d", st_err, errs); end
`endif
  endtask
  initial begin
    for (int i = 0; i < 8; i++) pool[i] = 15'(i * 291 + 5);
    seq = '0;
    test_reset();
    test_write_read();
    test_absent();
    test_backpressure();
    test_illegal();
    test_midreset();
    test_random_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end
endmodule
